store_buf: RTL and testbench
============================

Name: store_buf

Overview:
- Posted-write buffer between the MEM-stage store path and the data memory.
- Queues word/byte-enabled store requests in FIFO order and drains one per cycle to the data memory write port.
- The CPU does not stall on a store unless the buffer is full.
- Detects load-after-store hazards to queued addresses and requests a stall until those stores have drained.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
PTR_W, 2, log2(DEPTH); pointer width
ADDR_W, 32, byte-address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
st_valid  in  1  store request from MEM stage
st_addr  in  ADDR_W  store byte address
st_wdata  in  32  store data, already lane-aligned
st_be  in  4  byte enables; bit i covers st_wdata[8i+7:8i]
st_pc  in  32  PC of the store instruction; carried through for trace
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  load in MEM stage this cycle
ld_addr  in  ADDR_W  load byte address
ld_stall  out  1  load word-address matches a queued store
dm_we  out  1  head entry valid; write request to data memory
dm_addr  out  ADDR_W  head address
dm_wdata  out  32  head data
dm_be  out  4  head byte enables
dm_pc  out  32  head PC
dm_ready  in  1  data memory accepts the write at this edge
count  out  PTR_W+1  occupied entries
empty  out  1  count == 0

Behaviour:
- Storage:
  - DEPTH entries of {addr, wdata, be, pc} plus a per-entry valid bit.
  - Write pointer wp, read pointer rp, and count are all registers.
- Reset:
  - Asynchronous, taking effect while reset == 0.
  - wp = rp = count = 0 and all valid bits = 0.
  - Resulting outputs: dm_we = 0, empty = 1, st_ready = 1, ld_stall = 0.
  - Entry payloads need not be cleared.
  - Reset mid-operation discards all queued stores; nothing is written to memory after reset asserts.
- Enqueue: when st_valid && st_ready, the entry is written at wp, valid[wp] is set, and wp wraps modulo DEPTH at the edge.
- Dequeue:
  - dm_we = valid[rp]; the dm_* outputs are combinational reads of entry rp.
  - When dm_we && dm_ready, valid[rp] is cleared and rp wraps modulo DEPTH at the edge.
- Latency: a store enqueued at edge N drives dm_we in the cycle after N and is earliest written at edge N+1.
- Full: st_ready = (count != DEPTH).
  - A simultaneous dequeue does not free a slot for the same cycle; there is no pass-through.
  - st_valid with st_ready = 0 is ignored; the MEM stage holds the request.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Empty: dm_we = 0 and the dm_* payload is don't-care.
- Hazard detection:
  - ld_stall = ld_valid && OR over i of (valid[i] && entry[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]).
  - Comparison is at word granularity; byte enables are ignored.
  - Combinational; it deasserts in the cycle after the last matching entry drains.
  - st_addr in the same cycle is not compared.
- Ordering: stores reach memory strictly in issue order. Stores to the same word are not merged.
- Address bits [1:0] pass through unmodified.

Optional Feature:
- Macro: STORE_BUF_TRACE_EN.
- When defined: at every drain edge (dm_we && dm_ready, not in reset), the block prints a line in the format "@<dm_pc hex>: *<dm_addr hex> <= <dm_wdata hex>".
  - The data field is dm_wdata with lanes whose dm_be bit is 0 shown as 00.
- When undefined: no $display and no simulation-only code.
- Ports and the dm_pc path are identical in both builds.

Decomposition:
- Shared package store_buf_pkg holds:
  - entry field widths
  - constant BE_WORD = 4'b1111
  - the word-address slice helper function
- One sub-module: store_buf_match, the DEPTH-wide parallel word-address comparator producing ld_stall.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with st_valid = 1 -> dm_we = 0, count = 0, empty = 1, st_ready = 1; no enqueue occurs.
- Single store: st addr 0x0000_0010, data 0xDEAD_BEEF, be 4'hF, pc 0x0000_3004, dm_ready = 1 -> the next cycle dm_we = 1 with the same payload; the following cycle empty = 1.
- Fill: dm_ready = 0, 5 back-to-back stores to 0x0, 0x4, 0x8, 0xC, 0x10 -> the first 4 are accepted, count = 4 and st_ready = 0 on the fifth; after dm_ready = 1 they drain in order 0x0 to 0xC over 4 cycles.
- Full plus simultaneous drain: count = 4, dm_ready = 1, st_valid = 1 -> store rejected, count = 3 next cycle; a store the cycle after is accepted and count stays 3.
- Hazard: queue a store to 0x0000_0020 with dm_ready = 0, then ld_valid with ld_addr 0x0000_0022 -> ld_stall = 1; with ld_addr 0x0000_0024 -> ld_stall = 0; raise dm_ready -> ld_stall = 0 the cycle after the drain.
- Async reset mid-drain: count = 3, pulse reset low between edges -> dm_we drops immediately, count = 0, and no further writes appear or trace lines print.

Source files
------------

// File: rtl/store_buf_pkg.sv
// Shared types and helpers for the posted-write store buffer.
package store_buf_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned MAX_ADDR_W = 64;

  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [PC_W-1:0]   pc;
  } sb_payload_t;

  // Word address: byte offset bits cleared so compares ignore lane position.
  function automatic logic [MAX_ADDR_W-1:0] word_addr(input logic [MAX_ADDR_W-1:0] addr);
    return {addr[MAX_ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = '0;
    if (be == BE_WORD) begin
      mask = '1;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        mask[8*i +: 8] = {8{be[i]}};
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/store_buf_match.sv
// Parallel word-address comparator flagging loads that hit a queued store.
import store_buf_pkg::*;

module store_buf_match #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                          ld_valid,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DEPTH-1:0]              entry_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
  output logic                          ld_stall
);

  logic [DEPTH-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = entry_valid[i] &&
               (word_addr(MAX_ADDR_W'(entry_addr[i])) == word_addr(MAX_ADDR_W'(ld_addr)));
    end
  end

  assign ld_stall = ld_valid && (|hit);

endmodule

// File: rtl/store_buf.sv
// Posted-write store buffer: FIFO of byte-enabled stores drained one per cycle.
// Optional drain trace enabled by defining STORE_BUF_TRACE_EN.
import store_buf_pkg::*;

module store_buf #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_wdata,
  input  logic [3:0]        st_be,
  input  logic [31:0]       st_pc,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_stall,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_pc,
  input  logic              dm_ready,
  output logic [PTR_W:0]    count,
  output logic              empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  sb_payload_t [DEPTH-1:0]      pay_q;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PTR_W-1:0]             wp_q, wp_d, rp_q, rp_d;
  logic [PTR_W:0]               count_q, count_d;
  logic                         enq, deq;
  sb_payload_t                  head;

  // No pass-through: a drain in the same cycle does not make room for a store.
  assign st_ready = (count_q != FULL_CNT);
  assign enq      = st_valid && st_ready;
  assign deq      = dm_we && dm_ready;

  assign head     = pay_q[rp_q];
  assign dm_we    = valid_q[rp_q];
  assign dm_addr  = addr_q[rp_q];
  assign dm_wdata = head.wdata;
  assign dm_be    = head.be;
  assign dm_pc    = head.pc;
  assign count    = count_q;
  assign empty    = (count_q == '0);

  always_comb begin
    valid_d = valid_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (enq) begin
      valid_d[wp_q] = 1'b1;
      wp_d          = wp_q + PTR_W'(1);
    end
    if (deq) begin
      valid_d[rp_q] = 1'b0;
      rp_d          = rp_q + PTR_W'(1);
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Payload storage is qualified by valid bits, so it is left unreset.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wp_q] <= st_addr;
      pay_q[wp_q]  <= '{wdata: st_wdata, be: st_be, pc: st_pc};
    end
  end

  store_buf_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .entry_valid (valid_q),
    .entry_addr  (addr_q),
    .ld_stall    (ld_stall)
  );

`ifdef STORE_BUF_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && deq) begin
      $display("@%h: *%h <= %h", dm_pc, dm_addr, dm_wdata & lane_mask(dm_be));
    end
  end
`endif

endmodule

// File: tb/tb_store_buf.sv
// Self-checking bench for store_buf against a queue-based reference model.
module tb_store_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_wdata, st_pc;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_pc;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [2:0]  count;
  logic        empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  store_buf #(
    .DEPTH  (4),
    .PTR_W  (2),
    .ADDR_W (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .st_pc    (st_pc),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_stall (ld_stall),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .dm_pc    (dm_pc),
    .dm_ready (dm_ready),
    .count    (count),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    logic acc, drn, stall_exp;
    @(negedge clk);
    if (!reset) q.delete();
    chk("dm_we",    64'(dm_we),    64'(q.size() != 0));
    chk("count",    64'(count),    64'(q.size()));
    chk("empty",    64'(empty),    64'(q.size() == 0));
    chk("st_ready", 64'(st_ready), 64'(q.size() != DEPTH));
    stall_exp = 1'b0;
    if (ld_valid) begin
      foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) stall_exp = 1'b1;
    end
    chk("ld_stall", 64'(ld_stall), 64'(stall_exp));
    if (q.size() != 0) begin
      chk("dm_addr",  64'(dm_addr),  64'(q[0].addr));
      chk("dm_wdata", 64'(dm_wdata), 64'(q[0].wdata));
      chk("dm_be",    64'(dm_be),    64'(q[0].be));
      chk("dm_pc",    64'(dm_pc),    64'(q[0].pc));
    end
    acc = reset && st_valid && (q.size() < DEPTH);
    drn = reset && (q.size() != 0) && dm_ready;
    @(posedge clk);
    if (drn) q.delete(0);
    if (acc) q.push_back('{addr: st_addr, wdata: st_wdata, be: st_be, pc: st_pc});
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_be    = 4'hF;
    st_pc    = 32'h1000 + a;
    cycle();
    st_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    st_valid = 1'b1;
    st_addr  = 32'h40;
    st_wdata = 32'h1234_5678;
    st_be    = 4'hF;
    st_pc    = 32'h0;
    ld_valid = 1'b0;
    ld_addr  = 32'h0;
    dm_ready = 1'b1;

    // Reset held with a store pending: nothing may enqueue.
    cycle();
    cycle();
    st_valid = 1'b0;
    reset    = 1'b1;
    cycle();

    // Single store, then empty again.
    st_valid = 1'b1;
    st_addr  = 32'h0000_0010;
    st_wdata = 32'hDEAD_BEEF;
    st_be    = 4'hF;
    st_pc    = 32'h0000_3004;
    cycle();
    st_valid = 1'b0;
    cycle();
    cycle();

    // Fill with dm_ready low; fifth store must be refused.
    dm_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(32'(i * 4), 32'hA000_0000 + 32'(i));
    cycle();
    dm_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Full plus simultaneous drain: rejected, then accepted with count steady.
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i));
    dm_ready = 1'b1;
    store(32'h200, 32'hC000_0000);
    store(32'h204, 32'hC000_0001);
    for (int i = 0; i < 5; i++) cycle();

    // Load-after-store hazard at word granularity.
    dm_ready = 1'b0;
    store(32'h0000_0020, 32'h5555_AAAA);
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0022;
    cycle();
    ld_addr  = 32'h0000_0024;
    cycle();
    ld_addr  = 32'h0000_0020;
    dm_ready = 1'b1;
    cycle();
    cycle();
    ld_valid = 1'b0;

    // Asynchronous reset pulse between edges with three stores queued.
    dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h300 + 32'(i * 4), 32'hD000_0000 + 32'(i));
    #1 reset = 1'b0;
    #1;
    chk("async_dm_we", 64'(dm_we), 64'(0));
    chk("async_count", 64'(count), 64'(0));
    chk("async_empty", 64'(empty), 64'(1));
    q.delete();
    #1 reset = 1'b1;
    dm_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic over a small address window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = 32'($urandom_range(0, 31));
      st_wdata = $urandom;
      st_be    = 4'($urandom_range(1, 15));
      st_pc    = $urandom;
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 32'($urandom_range(0, 31));
      dm_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
